// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: jump-sequencer state encoding and register-file constants.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } jump_state_t;

endpackage

// File: rtl/jump_hazard_detect.sv
// Combinational detector: a JR/JALR in ID whose rs is still being produced by EX or loaded in MEM.
module jump_hazard_detect #(
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  i_jump_reg,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_ex_regwrite,
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_mem_memread,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    output logic                  o_hz
);
    import mips_pkg::*;

    logic w_rs_live;
    logic w_ex_hit;
    logic w_mem_hit;

    // $zero is never a real dependency, whatever EX/MEM claim to write.
    assign w_rs_live = (i_rs != REG_ADDR_W'(REG_ZERO));
    assign w_ex_hit  = (i_ex_regwrite | i_ex_memread) & (i_ex_rd == i_rs);
    assign w_mem_hit = i_mem_memread & (i_mem_rd == i_rs);
    assign o_hz      = i_jump_reg & w_rs_live & (w_ex_hit | w_mem_hit);

endmodule

// File: rtl/jump_ctrl.sv
// Decode-stage jump sequencer: redirects the PC, stalls register-target jumps on rs hazards, keeps debug counters.
// Build option JUMP_DELAY_SLOT_EN: keep the delay-slot instruction (no IF/ID flush on redirect).
module jump_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16,
    parameter int MAX_STALL  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_jump,
    input  logic                  i_jump_reg,
    input  logic [DATA_WIDTH-1:0] i_pcjump,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_ex_regwrite,
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_mem_memread,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    output logic                  o_pc_sel,
    output logic [DATA_WIDTH-1:0] o_pc_target,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_ifid_flush,
    output logic                  o_idex_bubble,
    output logic                  o_stalled,
    output logic                  o_stall_err,
    output logic [CNT_W-1:0]      o_jump_count,
    output logic [CNT_W-1:0]      o_stall_count
);
    import mips_pkg::*;

    localparam logic [CNT_W-1:0] STALL_SAT = CNT_W'(MAX_STALL);

`ifdef JUMP_DELAY_SLOT_EN
    localparam logic FLUSH_ON_REDIRECT = 1'b0;
`else
    localparam logic FLUSH_ON_REDIRECT = 1'b1;
`endif

    jump_state_t      r_state;
    jump_state_t      w_state_next;
    logic [CNT_W-1:0] r_jump_count;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_stall_cyc;
    logic             r_stall_err;
    logic             r_flushed;

    logic w_hz;
    logic w_jump;
    logic w_redirect;
    logic w_stall_now;
    logic w_flush;
    logic w_err_hit;

    jump_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .i_jump_reg    (i_jump_reg),
        .i_rs          (i_rs),
        .i_ex_regwrite (i_ex_regwrite),
        .i_ex_memread  (i_ex_memread),
        .i_ex_rd       (i_ex_rd),
        .i_mem_memread (i_mem_memread),
        .i_mem_rd      (i_mem_rd),
        .o_hz          (w_hz)
    );

    // The slot right after a flushing redirect holds a NOP, so a stale i_jump there is ignored.
    assign w_jump = i_jump & ~r_flushed;

    always_comb begin
        w_state_next  = r_state;
        w_redirect    = 1'b0;
        w_stall_now   = 1'b0;
        w_flush       = 1'b0;
        o_pc_sel      = 1'b0;
        o_pc_write    = i_enable;
        o_ifid_write  = i_enable;
        o_idex_bubble = 1'b0;
        if (i_enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_jump && w_hz) begin
                        w_stall_now  = 1'b1;
                        w_state_next = ST_STALL;
                    end else if (w_jump) begin
                        w_redirect = 1'b1;
                    end
                end
                ST_STALL: begin
                    if (w_hz) begin
                        w_stall_now = 1'b1;
                    end else begin
                        w_redirect   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
        if (w_stall_now) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
        end
        if (w_redirect) begin
            o_pc_sel = 1'b1;
            w_flush  = FLUSH_ON_REDIRECT;
        end
    end

    // Error fires during the MAX_STALL-th consecutive stall cycle, then latches.
    assign w_err_hit = w_stall_now && ((r_stall_cyc + 1'b1) >= STALL_SAT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_jump_count  <= '0;
            r_stall_count <= '0;
            r_stall_cyc   <= '0;
            r_stall_err   <= 1'b0;
            r_flushed     <= 1'b0;
        end else if (i_enable) begin
            r_state   <= w_state_next;
            r_flushed <= w_flush;
            if (w_redirect) begin
                r_jump_count <= r_jump_count + 1'b1;
            end
            if (w_stall_now) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (!w_stall_now) begin
                r_stall_cyc <= '0;
            end else if (r_stall_cyc < STALL_SAT) begin
                r_stall_cyc <= r_stall_cyc + 1'b1;
            end
            if (w_err_hit) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign o_pc_target   = i_pcjump;
    assign o_ifid_flush  = w_flush;
    assign o_stalled     = (r_state == ST_STALL);
    assign o_stall_err   = r_stall_err | w_err_hit;
    assign o_jump_count  = r_jump_count;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl; honours JUMP_DELAY_SLOT_EN for the flush expectations.
module tb_jump_ctrl;

`ifdef JUMP_DELAY_SLOT_EN
    localparam logic DS = 1'b1;
`else
    localparam logic DS = 1'b0;
`endif
    localparam logic EXP_FLUSH = ~DS;

    logic        i_clk = 1'b0;
    logic        i_reset, i_enable, i_jump, i_jump_reg;
    logic [31:0] i_pcjump;
    logic [4:0]  i_rs, i_ex_rd, i_mem_rd;
    logic        i_ex_regwrite, i_ex_memread, i_mem_memread;
    logic        o_pc_sel, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble;
    logic        o_stalled, o_stall_err;
    logic [31:0] o_pc_target;
    logic [15:0] o_jump_count, o_stall_count;

    int n_total = 0;
    int n_bad   = 0;
    int exp_jc  = 0;

    jump_ctrl dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_jump        (i_jump),
        .i_jump_reg    (i_jump_reg),
        .i_pcjump      (i_pcjump),
        .i_rs          (i_rs),
        .i_ex_regwrite (i_ex_regwrite),
        .i_ex_memread  (i_ex_memread),
        .i_ex_rd       (i_ex_rd),
        .i_mem_memread (i_mem_memread),
        .i_mem_rd      (i_mem_rd),
        .o_pc_sel      (o_pc_sel),
        .o_pc_target   (o_pc_target),
        .o_pc_write    (o_pc_write),
        .o_ifid_write  (o_ifid_write),
        .o_ifid_flush  (o_ifid_flush),
        .o_idex_bubble (o_idex_bubble),
        .o_stalled     (o_stalled),
        .o_stall_err   (o_stall_err),
        .o_jump_count  (o_jump_count),
        .o_stall_count (o_stall_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic quiet();
        i_jump = 0; i_jump_reg = 0; i_rs = 0; i_pcjump = 0;
        i_ex_regwrite = 0; i_ex_memread = 0; i_ex_rd = 0;
        i_mem_memread = 0; i_mem_rd = 0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic jr_hz(input logic [4:0] rs, input logic [31:0] tgt);
        quiet();
        i_jump = 1; i_jump_reg = 1; i_rs = rs; i_pcjump = tgt;
        i_ex_regwrite = 1; i_ex_rd = rs;
    endtask

    initial begin
        quiet();
        i_enable = 1;
        i_reset  = 1;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 0;
        #1;
        chk("rst_pc_write",   32'(o_pc_write), 1);
        chk("rst_ifid_write", 32'(o_ifid_write), 1);
        chk("rst_pc_sel",     32'(o_pc_sel), 0);
        chk("rst_stalled",    32'(o_stalled), 0);
        chk("rst_err",        32'(o_stall_err), 0);
        chk("rst_jcount",     32'(o_jump_count), 0);

        // J to 0x40 from IDLE
        next_cycle();
        i_jump = 1; i_pcjump = 32'h40; #1;
        chk("j_pc_sel",   32'(o_pc_sel), 1);
        chk("j_target",   o_pc_target, 32'h40);
        chk("j_flush",    32'(o_ifid_flush), 32'(EXP_FLUSH));
        chk("j_pc_write", 32'(o_pc_write), 1);
        chk("j_jcount0",  32'(o_jump_count), 0);
        exp_jc = 1;

        // jump still asserted in the following slot
        next_cycle(); #1;
        chk("j_jcount1",     32'(o_jump_count), 1);
        chk("j_next_pc_sel", 32'(o_pc_sel), 32'(DS));
        chk("j_next_flush",  32'(o_ifid_flush), 0);
        if (DS) exp_jc++;

        // JR $zero with EX writing $zero: no stall
        next_cycle();
        quiet(); i_jump = 1; i_jump_reg = 1; i_rs = 0;
        i_ex_regwrite = 1; i_ex_rd = 0; i_pcjump = 32'h100; #1;
        chk("jr0_pc_sel", 32'(o_pc_sel), 1);
        chk("jr0_bubble", 32'(o_idex_bubble), 0);
        chk("jr0_target", o_pc_target, 32'h100);
        chk("jr0_jcount", 32'(o_jump_count), 32'(exp_jc));
        exp_jc++;

        next_cycle(); quiet(); #1;
        chk("q1_jcount", 32'(o_jump_count), 32'(exp_jc));

        // JR rs=5, load in EX then MEM
        next_cycle();
        i_jump = 1; i_jump_reg = 1; i_rs = 5; i_pcjump = 32'h200;
        i_ex_memread = 1; i_ex_rd = 5; #1;
        chk("ld1_pc_write",   32'(o_pc_write), 0);
        chk("ld1_ifid_write", 32'(o_ifid_write), 0);
        chk("ld1_bubble",     32'(o_idex_bubble), 1);
        chk("ld1_pc_sel",     32'(o_pc_sel), 0);
        chk("ld1_stalled",    32'(o_stalled), 0);
        next_cycle();
        i_ex_memread = 0; i_ex_rd = 0; i_mem_memread = 1; i_mem_rd = 5; #1;
        chk("ld2_stalled",  32'(o_stalled), 1);
        chk("ld2_pc_write", 32'(o_pc_write), 0);
        chk("ld2_scount",   32'(o_stall_count), 1);
        next_cycle();
        i_mem_memread = 0; i_mem_rd = 0; #1;
        chk("ld3_pc_sel",   32'(o_pc_sel), 1);
        chk("ld3_target",   o_pc_target, 32'h200);
        chk("ld3_flush",    32'(o_ifid_flush), 32'(EXP_FLUSH));
        chk("ld3_pc_write", 32'(o_pc_write), 1);
        chk("ld3_scount",   32'(o_stall_count), 2);
        exp_jc++;
        next_cycle(); quiet(); #1;
        chk("ld4_stalled", 32'(o_stalled), 0);
        chk("ld4_jcount",  32'(o_jump_count), 32'(exp_jc));
        chk("ld4_err",     32'(o_stall_err), 0);

        // hazard held five cycles: error during the fourth
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            jr_hz(5'd7, 32'h300); #1;
            chk($sformatf("long%0d_err", k), 32'(o_stall_err), (k >= 4) ? 1 : 0);
            chk($sformatf("long%0d_scount", k), 32'(o_stall_count), 32'(2 + k - 1));
        end

        // freeze mid-STALL
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            i_enable = 0; #1;
            chk($sformatf("frz%0d_pc_write", k), 32'(o_pc_write), 0);
            chk($sformatf("frz%0d_bubble", k),   32'(o_idex_bubble), 0);
            chk($sformatf("frz%0d_pc_sel", k),   32'(o_pc_sel), 0);
            chk($sformatf("frz%0d_scount", k),   32'(o_stall_count), 7);
        end
        next_cycle();
        i_enable = 1; #1;
        chk("resume_bubble", 32'(o_idex_bubble), 1);
        chk("resume_scount", 32'(o_stall_count), 7);
        next_cycle();
        i_ex_regwrite = 0; #1;
        chk("long_pc_sel", 32'(o_pc_sel), 1);
        chk("long_target", o_pc_target, 32'h300);
        chk("long_scount", 32'(o_stall_count), 8);
        exp_jc++;
        next_cycle(); quiet(); #1;
        chk("sticky_err",  32'(o_stall_err), 1);
        chk("long_jcount", 32'(o_jump_count), 32'(exp_jc));

        // reset taken while in STALL
        next_cycle();
        jr_hz(5'd9, 32'h400);
        next_cycle(); #1;
        chk("pre_rst_stalled", 32'(o_stalled), 1);
        i_reset = 1;
        next_cycle();
        i_reset = 0; quiet(); #1;
        chk("rst2_stalled",    32'(o_stalled), 0);
        chk("rst2_err",        32'(o_stall_err), 0);
        chk("rst2_jcount",     32'(o_jump_count), 0);
        chk("rst2_scount",     32'(o_stall_count), 0);
        chk("rst2_pc_write",   32'(o_pc_write), 1);
        chk("rst2_ifid_write", 32'(o_ifid_write), 1);
        chk("rst2_bubble",     32'(o_idex_bubble), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
